// File: rtl/buf_exec_pkg.sv
// Shared encodings for the buffered command executor: FSM states, command word layout, opcodes.
package buf_exec_pkg;

    localparam int DATA_WIDTH      = 40;
    localparam int FIFO_DEPTH      = 16;
    localparam int START_THRESHOLD = 2;
    localparam int START_TIMEOUT   = 15;
    localparam int ABORT_HOLD      = 4;

    localparam int OPC_HI = 39;
    localparam int OPC_LO = 32;

    localparam logic [7:0] OPC_NOP = 8'h80;
    localparam logic [7:0] OPC_EOB = 8'hBF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_ABORT = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    function automatic logic [7:0] opcode_of(input logic [DATA_WIDTH-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/buf_exec_rr_arb2.sv
// Two-way round-robin arbiter with block lock; grant appears the cycle after valid and is held until
// the last word of the block is accepted (release) or abort clears it; inhibit blocks new grants.
module buf_exec_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       blk_release,
    input  logic       clear,
    input  logic       inhibit,
    output logic [1:0] grant
);

    logic [1:0] r_grant;
    logic       r_prefer1;
    logic [1:0] w_pick;

    // On a tie the previous owner loses.
    always_comb begin
        w_pick = 2'b00;
        if (valid == 2'b11) begin
            w_pick = r_prefer1 ? 2'b10 : 2'b01;
        end else if (valid[0]) begin
            w_pick = 2'b01;
        end else if (valid[1]) begin
            w_pick = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant   <= 2'b00;
            r_prefer1 <= 1'b0;
        end else if (clear || ((r_grant != 2'b00) && blk_release)) begin
            r_grant <= 2'b00;
        end else if ((r_grant == 2'b00) && !inhibit && (w_pick != 2'b00)) begin
            r_grant   <= w_pick;
            r_prefer1 <= w_pick[0];
        end
    end

    assign grant = r_grant;

endmodule

// File: rtl/buf_exec_ctrl.sv
// Command-FIFO write arbiter and executor start/abort sequencer; accepted words reach the FIFO one cycle
// later, requesters stall on full FIFO or abort recovery. BUF_EXEC_CTRL_STATS_EN adds activity counters.
module buf_exec_ctrl #(
    parameter int DATA_WIDTH      = buf_exec_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH      = buf_exec_pkg::FIFO_DEPTH,
    parameter int START_THRESHOLD = buf_exec_pkg::START_THRESHOLD,
    parameter int START_TIMEOUT   = buf_exec_pkg::START_TIMEOUT,
    parameter int ABORT_HOLD      = buf_exec_pkg::ABORT_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_enable,
    input  logic                  ctrl_abort,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,
    output logic                  fifo_write,
    output logic [DATA_WIDTH-1:0] fifo_write_data,
    input  logic [31:0]           fifo_data_count,
    output logic                  be_start,
    output logic                  be_abort,
    input  logic                  be_busy,
    output logic [1:0]            grant,
    output logic [2:0]            state,
    output logic                  blk_dropped,
    output logic                  err_start_timeout
`ifdef BUF_EXEC_CTRL_STATS_EN
    ,
    output logic [31:0]           stat_words,
    output logic [15:0]           stat_starts,
    output logic [15:0]           stat_drops
`endif
);
    import buf_exec_pkg::*;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_timer;
    logic                  r_fifo_write;
    logic [DATA_WIDTH-1:0] r_fifo_write_data;
    logic                  r_be_start;
    logic                  r_be_abort;
    logic                  r_blk_dropped;
    logic                  r_err;
    logic                  r_mid;
    logic                  r_blk_pend;

    logic [1:0]            w_grant;
    logic                  w_blocked;
    logic                  w_space;
    logic                  w_acc0;
    logic                  w_acc1;
    logic                  w_acc;
    logic                  w_acc_last;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic                  w_abort_take;
    logic                  w_mid_nxt;
    logic                  w_count_zero;
    logic                  w_fire_start;
    logic                  w_set_err;

    assign w_blocked    = (r_state == ST_ABORT) || (r_state == ST_HOLD);
    // The registered write is not yet reflected in fifo_data_count, so reserve a slot for it.
    assign w_space      = ({1'b0, fifo_data_count} + {32'd0, r_fifo_write}) < 33'(FIFO_DEPTH);
    assign req0_ready   = w_grant[0] & w_space & ~w_blocked;
    assign req1_ready   = w_grant[1] & w_space & ~w_blocked;
    assign w_acc0       = req0_valid & req0_ready;
    assign w_acc1       = req1_valid & req1_ready;
    assign w_acc        = w_acc0 | w_acc1;
    assign w_acc_last   = w_acc0 ? req0_last : (w_acc1 & req1_last);
    assign w_acc_data   = w_acc0 ? req0_data : req1_data;
    assign w_abort_take = ctrl_abort & ~w_blocked;
    assign w_mid_nxt    = w_acc ? ~w_acc_last : r_mid;
    assign w_count_zero = (fifo_data_count == 32'd0);

    buf_exec_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid       ({req1_valid, req0_valid}),
        .blk_release (w_acc & w_acc_last),
        .clear       (w_abort_take),
        .inhibit     (w_blocked),
        .grant       (w_grant)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_fire_start = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_fifo_write) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (ctrl_enable && ((fifo_data_count >= 32'(START_THRESHOLD)) ||
                                    (r_blk_pend && !w_count_zero))) begin
                    w_state_nxt  = ST_START;
                    w_fire_start = 1'b1;
                end
            end
            ST_START: begin
                if (be_busy) begin
                    w_state_nxt = ST_RUN;
                end else if (r_timer >= 8'(START_TIMEOUT - 1)) begin
                    w_state_nxt = ST_FILL;
                    w_set_err   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!be_busy) begin
                    w_state_nxt = (w_count_zero && !r_fifo_write && !w_acc) ? ST_IDLE : ST_FILL;
                end
            end
            ST_ABORT: begin
                if (!be_busy) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_timer >= 8'(ABORT_HOLD - 1)) begin
                    w_state_nxt = w_count_zero ? ST_IDLE : ST_FILL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort_take) begin
            w_state_nxt  = ST_ABORT;
            w_fire_start = 1'b0;
            w_set_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= ST_IDLE;
            r_timer           <= 8'd0;
            r_fifo_write      <= 1'b0;
            r_fifo_write_data <= '0;
            r_be_start        <= 1'b0;
            r_be_abort        <= 1'b0;
            r_blk_dropped     <= 1'b0;
            r_err             <= 1'b0;
            r_mid             <= 1'b0;
            r_blk_pend        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Timer counts cycles spent in the current state and saturates.
            if (w_state_nxt != r_state) begin
                r_timer <= 8'd0;
            end else if (r_timer != 8'hFF) begin
                r_timer <= r_timer + 8'd1;
            end
            r_fifo_write <= w_acc;
            if (w_acc) r_fifo_write_data <= w_acc_data;
            r_be_start    <= w_fire_start;
            r_be_abort    <= w_abort_take;
            r_blk_dropped <= w_abort_take & w_mid_nxt;
            r_err         <= r_err | w_set_err;
            r_mid         <= w_abort_take ? 1'b0 : w_mid_nxt;
            if (w_abort_take) begin
                r_blk_pend <= 1'b0;
            end else if (w_acc && w_acc_last) begin
                r_blk_pend <= 1'b1;
            end else if (w_fire_start) begin
                r_blk_pend <= 1'b0;
            end
        end
    end

    assign fifo_write        = r_fifo_write;
    assign fifo_write_data   = r_fifo_write_data;
    assign be_start          = r_be_start;
    assign be_abort          = r_be_abort;
    assign grant             = w_grant;
    assign state             = r_state;
    assign blk_dropped       = r_blk_dropped;
    assign err_start_timeout = r_err;

`ifdef BUF_EXEC_CTRL_STATS_EN
    logic [31:0] r_stat_words;
    logic [15:0] r_stat_starts;
    logic [15:0] r_stat_drops;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_words  <= 32'd0;
            r_stat_starts <= 16'd0;
            r_stat_drops  <= 16'd0;
        end else begin
            if (w_acc)                      r_stat_words  <= r_stat_words + 32'd1;
            if (w_fire_start)               r_stat_starts <= r_stat_starts + 16'd1;
            if (w_abort_take && w_mid_nxt)  r_stat_drops  <= r_stat_drops + 16'd1;
        end
    end

    assign stat_words  = r_stat_words;
    assign stat_starts = r_stat_starts;
    assign stat_drops  = r_stat_drops;
`endif

endmodule

// File: tb/tb_buf_exec_ctrl.sv
// Directed bench for buf_exec_ctrl: start sequencing, arbitration order, FIFO space, timeout, abort, reset.
module tb_buf_exec_ctrl;
    import buf_exec_pkg::*;

    logic        clk;
    logic        rst;
    logic        ctrl_enable;
    logic        ctrl_abort;
    logic        req0_valid;
    logic [39:0] req0_data;
    logic        req0_last;
    logic        req0_ready;
    logic        req1_valid;
    logic [39:0] req1_data;
    logic        req1_last;
    logic        req1_ready;
    logic        fifo_write;
    logic [39:0] fifo_write_data;
    logic [31:0] fifo_data_count;
    logic        be_start;
    logic        be_abort;
    logic        be_busy;
    logic [1:0]  grant;
    logic [2:0]  state;
    logic        blk_dropped;
    logic        err_start_timeout;
`ifdef BUF_EXEC_CTRL_STATS_EN
    logic [31:0] stat_words;
    logic [15:0] stat_starts;
    logic [15:0] stat_drops;
`endif

    int n_chk;
    int n_fail;

    buf_exec_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .ctrl_enable       (ctrl_enable),
        .ctrl_abort        (ctrl_abort),
        .req0_valid        (req0_valid),
        .req0_data         (req0_data),
        .req0_last         (req0_last),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_data         (req1_data),
        .req1_last         (req1_last),
        .req1_ready        (req1_ready),
        .fifo_write        (fifo_write),
        .fifo_write_data   (fifo_write_data),
        .fifo_data_count   (fifo_data_count),
        .be_start          (be_start),
        .be_abort          (be_abort),
        .be_busy           (be_busy),
        .grant             (grant),
        .state             (state),
        .blk_dropped       (blk_dropped),
        .err_start_timeout (err_start_timeout)
`ifdef BUF_EXEC_CTRL_STATS_EN
        ,
        .stat_words        (stat_words),
        .stat_starts       (stat_starts),
        .stat_drops        (stat_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic        exp_rdy0;
    } space_vec_t;

    space_vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        ctrl_enable     = 1'b0;
        ctrl_abort      = 1'b0;
        req0_valid      = 1'b0;
        req0_data       = '0;
        req0_last       = 1'b0;
        req1_valid      = 1'b0;
        req1_data       = '0;
        req1_last       = 1'b0;
        fifo_data_count = 32'd0;
        be_busy         = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},   64'(state), 64'd0);
        chk({tag, "_grant"},   64'(grant), 64'd0);
        chk({tag, "_fwr"},     64'(fifo_write), 64'd0);
        chk({tag, "_fdata"},   64'(fifo_write_data), 64'd0);
        chk({tag, "_start"},   64'(be_start), 64'd0);
        chk({tag, "_abort"},   64'(be_abort), 64'd0);
        chk({tag, "_drop"},    64'(blk_dropped), 64'd0);
        chk({tag, "_err"},     64'(err_start_timeout), 64'd0);
        chk({tag, "_rdy"},     64'({req1_ready, req0_ready}), 64'd0);
    endtask

    logic [39:0] w0[4];
    logic        l0[4];
    logic [39:0] w1[3];
    logic        l1[3];
    logic [39:0] got[8];
    logic [39:0] exp_ord[7];
    int          i0;
    int          i1;
    int          n_got;
    logic        a0;
    logic        a1;

    initial begin
        n_chk  = 0;
        n_fail = 0;

        tbl[0] = '{32'd0,          1'b1};
        tbl[1] = '{32'd14,         1'b1};
        tbl[2] = '{32'd15,         1'b1};
        tbl[3] = '{32'd16,         1'b0};
        tbl[4] = '{32'd31,         1'b0};
        tbl[5] = '{32'hFFFF_FFFF,  1'b0};

        // ---- reset state ----
        do_reset();
        chk_all_zero("rst");
        rst = 1'b1;

        // ---- two-word command, start, run, back to idle ----
        ctrl_enable = 1'b1;
        req0_valid  = 1'b1;
        req0_data   = {OPC_NOP, 32'd0};
        req0_last   = 1'b0;
        #1;
        chk("t1_rdy_before_grant", 64'(req0_ready), 64'd0);
        tick();
        chk("t1_grant", 64'(grant), 64'd1);
        chk("t1_rdy", 64'(req0_ready), 64'd1);
        tick();
        req0_data = {OPC_EOB, 32'd0};
        req0_last = 1'b1;
        #1;
        chk("t1_wr1", 64'(fifo_write), 64'd1);
        chk("t1_wr1_data", 64'(fifo_write_data), 64'h80_0000_0000);
        chk("t1_state_idle", 64'(state), 64'(ST_IDLE));
        tick();
        req0_valid      = 1'b0;
        req0_last       = 1'b0;
        fifo_data_count = 32'd1;
        chk("t1_wr2", 64'(fifo_write), 64'd1);
        chk("t1_wr2_data", 64'(fifo_write_data), 64'hBF_0000_0000);
        chk("t1_state_fill", 64'(state), 64'(ST_FILL));
        chk("t1_grant_rel", 64'(grant), 64'd0);
        tick();
        fifo_data_count = 32'd2;
        chk("t1_start", 64'(be_start), 64'd1);
        chk("t1_state_start", 64'(state), 64'(ST_START));
        chk("t1_no_wr", 64'(fifo_write), 64'd0);
        tick();
        be_busy = 1'b1;
        chk("t1_start_once", 64'(be_start), 64'd0);
        tick();
        chk("t1_state_run", 64'(state), 64'(ST_RUN));
        be_busy         = 1'b0;
        fifo_data_count = 32'd0;
        tick();
        chk("t1_state_back_idle", 64'(state), 64'(ST_IDLE));

        // ---- round-robin block-atomic arbitration ----
        do_reset();
        rst = 1'b1;
        w0[0] = 40'hA0_0000_0000; l0[0] = 1'b0;
        w0[1] = 40'hA1_0000_0001; l0[1] = 1'b0;
        w0[2] = 40'hA2_0000_0002; l0[2] = 1'b1;
        w0[3] = 40'hB0_0000_0003; l0[3] = 1'b1;
        w1[0] = 40'hC0_0000_0010; l1[0] = 1'b0;
        w1[1] = 40'hC1_0000_0011; l1[1] = 1'b0;
        w1[2] = 40'hC2_0000_0012; l1[2] = 1'b1;
        exp_ord[0] = w0[0]; exp_ord[1] = w0[1]; exp_ord[2] = w0[2];
        exp_ord[3] = w1[0]; exp_ord[4] = w1[1]; exp_ord[5] = w1[2];
        exp_ord[6] = w0[3];
        i0 = 0; i1 = 0; n_got = 0;
        for (int cyc = 0; cyc < 60 && n_got < 7; cyc++) begin
            req0_valid = (i0 < 4);
            req0_data  = (i0 < 4) ? w0[i0] : '0;
            req0_last  = (i0 < 4) ? l0[i0] : 1'b0;
            req1_valid = (i1 < 3);
            req1_data  = (i1 < 3) ? w1[i1] : '0;
            req1_last  = (i1 < 3) ? l1[i1] : 1'b0;
            #1;
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            if (a0 && a1) begin
                chk("t2_dual_ready", 64'd1, 64'd0);
            end
            @(posedge clk);
            if (a0) i0++;
            if (a1) i1++;
            #1;
            if (fifo_write && n_got < 8) begin
                got[n_got] = fifo_write_data;
                n_got++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t2_word_count", 64'(n_got), 64'd7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t2_order_%0d", k), 64'(got[k]), 64'(exp_ord[k]));
        end

        // ---- FIFO space with an in-flight write ----
        do_reset();
        rst             = 1'b1;
        fifo_data_count = 32'd14;
        req0_valid      = 1'b1;
        req0_data       = {OPC_NOP, 32'h55};
        req0_last       = 1'b0;
        tick();
        chk("t3_rdy_14", 64'(req0_ready), 64'd1);
        tick();
        req0_valid      = 1'b0;
        fifo_data_count = 32'd15;
        #1;
        chk("t3_inflight_wr", 64'(fifo_write), 64'd1);
        chk("t3_rdy_15_inflight", 64'(req0_ready), 64'd0);
        tick();
        chk("t3_rdy_15_settled", 64'(req0_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            fifo_data_count = tbl[k].cnt;
            #1;
            chk($sformatf("t3_tbl%0d_rdy0", k), 64'(req0_ready), 64'(tbl[k].exp_rdy0));
            chk($sformatf("t3_tbl%0d_rdy1", k), 64'(req1_ready), 64'd0);
            chk($sformatf("t3_tbl%0d_grant", k), 64'(grant), 64'd1);
        end

        // ---- start timeout ----
        do_reset();
        rst             = 1'b1;
        ctrl_enable     = 1'b1;
        fifo_data_count = 32'd2;
        req0_valid      = 1'b1;
        req0_data       = {OPC_EOB, 32'd0};
        req0_last       = 1'b1;
        tick();
        tick();
        req0_valid = 1'b0;
        req0_last  = 1'b0;
        tick();
        chk("t4_fill", 64'(state), 64'(ST_FILL));
        tick();
        fifo_data_count = 32'd1;
        chk("t4_start", 64'(be_start), 64'd1);
        for (int k = 0; k < 14; k++) tick();
        chk("t4_still_start", 64'(state), 64'(ST_START));
        chk("t4_err_not_yet", 64'(err_start_timeout), 64'd0);
        tick();
        chk("t4_err_set", 64'(err_start_timeout), 64'd1);
        chk("t4_back_fill", 64'(state), 64'(ST_FILL));
        for (int k = 0; k < 5; k++) tick();
        chk("t4_err_sticky", 64'(err_start_timeout), 64'd1);
        rst = 1'b0;
        tick();
        chk("t4_err_cleared", 64'(err_start_timeout), 64'd0);

        // ---- abort in the middle of a req1 block ----
        do_reset();
        rst        = 1'b1;
        be_busy    = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 40'hD0_0000_0000;
        req1_last  = 1'b0;
        tick();
        chk("t5_grant1", 64'(grant), 64'd2);
        tick();
        req1_data = 40'hD1_0000_0001;
        tick();
        req1_data  = 40'hD2_0000_0002;
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        req1_data  = 40'hD3_0000_0003;
        #1;
        chk("t5_word_written", 64'(fifo_write), 64'd1);
        chk("t5_word_data", 64'(fifo_write_data), 64'hD2_0000_0002);
        chk("t5_be_abort", 64'(be_abort), 64'd1);
        chk("t5_dropped", 64'(blk_dropped), 64'd1);
        chk("t5_grant_clr", 64'(grant), 64'd0);
        chk("t5_state_abort", 64'(state), 64'(ST_ABORT));
        chk("t5_rdy_low", 64'(req1_ready), 64'd0);
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        chk("t5_abort_pulse_end", 64'(be_abort), 64'd0);
        chk("t5_drop_pulse_end", 64'(blk_dropped), 64'd0);
        tick();
        chk("t5_abort_ignored", 64'(be_abort), 64'd0);
        chk("t5_wait_busy", 64'(state), 64'(ST_ABORT));
        be_busy = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_hold%0d_state", k), 64'(state), 64'(ST_HOLD));
            chk($sformatf("t5_hold%0d_rdy", k), 64'(req1_ready), 64'd0);
            tick();
        end
        chk("t5_idle", 64'(state), 64'(ST_IDLE));
        tick();
        chk("t5_regrant", 64'(grant), 64'd2);
        req1_valid = 1'b0;

        // ---- reset while running ----
        do_reset();
        rst             = 1'b1;
        ctrl_enable     = 1'b1;
        fifo_data_count = 32'd2;
        req0_valid      = 1'b1;
        req0_data       = {OPC_NOP, 32'h1234};
        req0_last       = 1'b1;
        tick();
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        chk("t6_start", 64'(be_start), 64'd1);
        be_busy = 1'b1;
        tick();
        chk("t6_run", 64'(state), 64'(ST_RUN));
        rst = 1'b0;
        tick();
        chk_all_zero("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
